pll_reset_sequencer: RTL

- Controls the system PLL's reset and holds the core's reset until the PLL output is stable.
- Sequence: pulses the PLL reset, waits for lock with a timeout and retries, then requires lock to stay stable before releasing `sys_reset`.
- Forces a full re-sequence if lock is lost for longer than a glitch window.
- Runs on the PLL reference clock, so it keeps running while the PLL is in reset.
- `sys_reset` is produced in the reference domain; the core-domain synchroniser sits downstream and is not part of this block.

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/lock_synchronizer.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encoding is visible on the debug port, so values are fixed.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUNNING   = 2'd3
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_GLITCH_CYCLES = 4;

    localparam int TCOUNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Two-flop synchroniser for a single asynchronous status bit.
// Latency 2 cycles; synchronous active-high reset clears both flops.
module lock_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for lock with timeout/retry, holds sys_reset until lock is stable.
// Runs on the reference clock; lock is synchronised (2 cycles) before any decision.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pll_lock,
    output logic                pll_rst,
    output logic                sys_reset,
    output logic                running,
    output logic [1:0]          state,
    output logic [TCOUNT_W-1:0] timeout_count
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam int GL_W  = $clog2(GLITCH_CYCLES) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GL_W-1:0]  GL_LAST  = GL_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GL_W-1:0]  GL_ONE   = GL_W'(1);
    localparam logic [TCOUNT_W-1:0] TC_ONE = TCOUNT_W'(1);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GL_W-1:0]     glitch_q, glitch_d;
    logic [TCOUNT_W-1:0] tcount_q, tcount_d;
    logic                pll_rst_q, sys_reset_q, running_q;
    logic                lock_s;

    lock_synchronizer u_lock_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (pll_lock),
        .sync_o  (lock_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PLL_RESET;
            cnt_q       <= '0;
            glitch_q    <= '0;
            tcount_q    <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            glitch_q    <= glitch_d;
            tcount_q    <= tcount_d;
            pll_rst_q   <= (state_d == PLL_RESET);
            sys_reset_q <= (state_d != RUNNING);
            running_q   <= (state_d == RUNNING);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        tcount_d = tcount_q;
        unique case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock wins over a timeout landing in the same cycle.
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = PLL_RESET;
                    cnt_d   = '0;
                    if (tcount_q != '1) begin
                        tcount_d = tcount_q + TC_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d  = RUNNING;
                    glitch_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUNNING: begin
                if (lock_s) begin
                    glitch_d = '0;
                end else if (glitch_q == GL_LAST) begin
                    state_d  = PLL_RESET;
                    cnt_d    = '0;
                    glitch_d = '0;
                end else begin
                    glitch_d = glitch_q + GL_ONE;
                end
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    assign pll_rst       = pll_rst_q;
    assign sys_reset     = sys_reset_q;
    assign running       = running_q;
    assign state         = state_q;
    assign timeout_count = tcount_q;

endmodule
